// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared command codes, feeder state encoding and image/run defaults
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lcd_pkg;

    localparam int IMG_BYTES_DEF = 108;
    localparam int CMD_NUM_DEF   = 22;
    localparam int CMD_AW_DEF    = 5;
    localparam int IMG_AW_DEF    = 7;

    localparam logic [2:0] CMD_LOAD = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_STREAM   = 3'd4,
        ST_GUARD    = 3'd5,
        ST_DONE     = 3'd6
    } feeder_state_t;

    function automatic logic is_load(input logic [2:0] code);
        return code == CMD_LOAD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_img_streamer.sv
// ============================================================================
// lcd_img_streamer : walks the image ROM once per load and gates bytes out
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_img_streamer
    import lcd_pkg::*;
#(
    parameter int IMG_BYTES = IMG_BYTES_DEF,
    parameter int IMG_AW    = IMG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_last,
    output logic [IMG_AW-1:0] o_img_rom_addr,
    input  logic [7:0]        i_img_rom_data,
    output logic [7:0]        o_datain
);

    localparam logic [IMG_AW-1:0] c_LAST_BYTE = IMG_AW'(IMG_BYTES - 1);
    localparam logic [IMG_AW-1:0] c_ONE       = IMG_AW'(1);

    logic              r_active;
    logic [IMG_AW-1:0] r_cnt;
    logic [IMG_AW-1:0] r_addr;

    // Address 0 is presented during the issue cycle, so the address register
    // runs one ahead of the byte counter while streaming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_addr   <= c_ONE;
        end else if (r_active) begin
            if (r_cnt == c_LAST_BYTE) begin
                r_active <= 1'b0;
                r_addr   <= '0;
            end else begin
                r_cnt  <= r_cnt + c_ONE;
                r_addr <= r_addr + c_ONE;
            end
        end
    end

    assign o_last         = r_active && (r_cnt == c_LAST_BYTE);
    assign o_img_rom_addr = r_addr;
    assign o_datain       = r_active ? i_img_rom_data : 8'h00;

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_feeder.sv
// ============================================================================
// lcd_cmd_feeder : sequences command/image ROMs into LCD_CTRL, honouring busy
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_cmd_feeder
    import lcd_pkg::*;
#(
    parameter int IMG_BYTES = IMG_BYTES_DEF,
    parameter int CMD_NUM   = CMD_NUM_DEF,
    parameter int CMD_AW    = CMD_AW_DEF,
    parameter int IMG_AW    = IMG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [CMD_AW-1:0] cmd_rom_addr,
    input  logic [2:0]        cmd_rom_data,
    output logic [IMG_AW-1:0] img_rom_addr,
    input  logic [7:0]        img_rom_data,
    input  logic              lcd_busy,
    output logic [2:0]        lcd_cmd,
    output logic              lcd_cmd_valid,
    output logic [7:0]        lcd_datain,
    output logic [CMD_AW-1:0] cmd_count,
    output logic              done
);

    localparam logic [CMD_AW-1:0] c_CMD_NUM = CMD_AW'(CMD_NUM);
    localparam logic [CMD_AW-1:0] c_ONE     = CMD_AW'(1);

    feeder_state_t r_state;
    logic          w_stream_start;
    logic          w_stream_last;

    assign w_stream_start = (r_state == ST_ISSUE) && is_load(lcd_cmd);

    lcd_img_streamer #(
        .IMG_BYTES (IMG_BYTES),
        .IMG_AW    (IMG_AW)
    ) u_streamer (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_stream_start),
        .o_last         (w_stream_last),
        .o_img_rom_addr (img_rom_addr),
        .i_img_rom_data (img_rom_data),
        .o_datain       (lcd_datain)
    );

    // lcd_cmd doubles as the latched command register; it is loaded from the
    // ROM output on the same edge that enters ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            cmd_rom_addr  <= '0;
            cmd_count     <= '0;
            lcd_cmd       <= '0;
            lcd_cmd_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_FETCH;
                        cmd_rom_addr <= '0;
                        cmd_count    <= '0;
                        done         <= 1'b0;
                    end
                end
                ST_FETCH: r_state <= ST_WAIT_RDY;
                ST_WAIT_RDY: begin
                    if (!lcd_busy) begin
                        r_state       <= ST_ISSUE;
                        lcd_cmd_valid <= 1'b1;
                        lcd_cmd       <= cmd_rom_data;
                    end
                end
                ST_ISSUE: begin
                    lcd_cmd_valid <= 1'b0;
                    lcd_cmd       <= '0;
                    cmd_count     <= (cmd_count == c_CMD_NUM) ? cmd_count : cmd_count + c_ONE;
                    r_state       <= is_load(lcd_cmd) ? ST_STREAM : ST_GUARD;
                end
                ST_STREAM: begin
                    if (w_stream_last) begin
                        r_state <= ST_GUARD;
                    end
                end
                // One dead cycle lets LCD_CTRL raise busy before it is sampled.
                ST_GUARD: begin
                    if (cmd_count == c_CMD_NUM) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        cmd_rom_addr <= cmd_count;
                        r_state      <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_cmd_feeder.sv
// ============================================================================
// tb_lcd_cmd_feeder : directed self-checking bench for lcd_cmd_feeder
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_cmd_feeder;
    import lcd_pkg::*;

    localparam int NB = IMG_BYTES_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic busy_manual;
    logic model_en;
    int   busy_cnt;
    logic lcd_busy;
    assign lcd_busy = model_en ? (busy_cnt != 0) : busy_manual;

    logic [2:0] cmd_mem [0:31];
    logic [7:0] img_mem [0:127];

    // main DUT: default parameters (22 commands per run)
    logic [4:0] d_cmd_addr, d_count;
    logic [6:0] d_img_addr;
    logic [2:0] d_cmd_data, d_cmd;
    logic [7:0] d_img_data, d_datain;
    logic       d_valid, d_done;

    // second DUT: one command per run
    logic [4:0] o1_cmd_addr, o1_count;
    logic [6:0] o1_img_addr;
    logic [2:0] o1_cmd_data, o1_cmd;
    logic [7:0] o1_img_data, o1_datain;
    logic       o1_valid, o1_done;

    int checks   = 0;
    int failures = 0;

    lcd_cmd_feeder u_dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_rom_addr(d_cmd_addr), .cmd_rom_data(d_cmd_data),
        .img_rom_addr(d_img_addr), .img_rom_data(d_img_data),
        .lcd_busy(lcd_busy), .lcd_cmd(d_cmd), .lcd_cmd_valid(d_valid),
        .lcd_datain(d_datain), .cmd_count(d_count), .done(d_done)
    );

    lcd_cmd_feeder #(.CMD_NUM(1)) u_one (
        .clk(clk), .reset(reset), .start(start),
        .cmd_rom_addr(o1_cmd_addr), .cmd_rom_data(o1_cmd_data),
        .img_rom_addr(o1_img_addr), .img_rom_data(o1_img_data),
        .lcd_busy(lcd_busy), .lcd_cmd(o1_cmd), .lcd_cmd_valid(o1_valid),
        .lcd_datain(o1_datain), .cmd_count(o1_count), .done(o1_done)
    );

    // synchronous ROMs, one read port per DUT
    always @(posedge clk) begin
        d_cmd_data  <= cmd_mem[d_cmd_addr];
        d_img_data  <= img_mem[d_img_addr];
        o1_cmd_data <= cmd_mem[o1_cmd_addr];
        o1_img_data <= img_mem[o1_img_addr];
    end

    // LCD_CTRL busy model: busy rises the cycle after a strobe
    always @(posedge clk) begin
        if (!model_en)
            busy_cnt <= 0;
        else if (d_valid)
            busy_cnt <= (d_cmd == CMD_LOAD) ? NB + 6 : 4;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [29:0] v;
        reset = 1'b0;
        repeat (2) step();
        v = {d_cmd_addr, d_img_addr, d_cmd, d_valid, d_datain, d_count, d_done};
        checks++;
        if (v !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs_main: got %h expected 0", v);
        end
        v = {o1_cmd_addr, o1_img_addr, o1_cmd, o1_valid, o1_datain, o1_count, o1_done};
        checks++;
        if (v !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs_one: got %h expected 0", v);
        end
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({d_valid, o1_valid, d_done, d_datain} !== 11'd0) begin
                failures++;
                $display("FAIL idle_no_activity: cycle %0d valid=%b/%b done=%b datain=%h expected all 0",
                         i, d_valid, o1_valid, d_done, d_datain);
            end
        end
    endtask

    task automatic test_single_load();
        cmd_mem[0] = CMD_LOAD;
        do_reset();
        pulse_start();
        step();
        step();
        checks++;
        if ({o1_valid, o1_cmd, o1_datain} !== 12'h800) begin
            failures++;
            $display("FAIL single_strobe: valid=%b cmd=%0d datain=%h expected 1/0/00", o1_valid, o1_cmd, o1_datain);
        end
        for (int k = 0; k < NB; k++) begin
            step();
            checks++;
            if ({o1_valid, o1_datain} !== {1'b0, 8'(k)}) begin
                failures++;
                $display("FAIL single_byte: k=%0d valid=%b datain=%h expected 0/%h", k, o1_valid, o1_datain, 8'(k));
            end
        end
        step();
        checks++;
        if ({o1_done, o1_datain} !== 9'd0) begin
            failures++;
            $display("FAIL single_guard: done=%b datain=%h expected 0/00", o1_done, o1_datain);
        end
        step();
        checks++;
        if (o1_done !== 1'b1 || o1_count !== 5'd1) begin
            failures++;
            $display("FAIL single_done: done=%b count=%0d expected 1/1", o1_done, o1_count);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (o1_valid !== 1'b0 || o1_done !== 1'b1) begin
                failures++;
                $display("FAIL single_after_done: valid=%b done=%b expected 0/1", o1_valid, o1_done);
            end
        end
    endtask

    task automatic test_busy_stall();
        cmd_mem[0] = 3'd1;
        cmd_mem[1] = 3'd2;
        for (int i = 2; i < 32; i++) cmd_mem[i] = 3'd1;
        model_en = 1'b0;
        busy_manual = 1'b0;
        do_reset();
        pulse_start();
        step();
        step();
        checks++;
        if (d_valid !== 1'b1 || d_cmd !== 3'd1) begin
            failures++;
            $display("FAIL stall_first_strobe: valid=%b cmd=%0d expected 1/1", d_valid, d_cmd);
        end
        busy_manual = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (d_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_held: cycle %0d valid=%b expected 0", i, d_valid);
            end
        end
        busy_manual = 1'b0;
        step();
        checks++;
        if (d_valid !== 1'b1 || d_cmd !== 3'd2 || d_count !== 5'd1) begin
            failures++;
            $display("FAIL stall_second_strobe: valid=%b cmd=%0d count=%0d expected 1/2/1", d_valid, d_cmd, d_count);
        end
        busy_manual = 1'b1;
        step();
        checks++;
        if (d_valid !== 1'b0 || d_count !== 5'd2) begin
            failures++;
            $display("FAIL stall_count: valid=%b count=%0d expected 0/2", d_valid, d_count);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (d_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_extra_strobe: cycle %0d valid=%b expected 0", i, d_valid);
            end
        end
        busy_manual = 1'b0;
    endtask

    task automatic test_full_run();
        logic [2:0] seq [22] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd0,
                                 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5};
        int   n = 0;
        int   left = 0;
        int   cyc = 0;
        logic prev_busy;
        for (int i = 0; i < 22; i++) cmd_mem[i] = seq[i];
        busy_manual = 1'b0;
        model_en = 1'b1;
        do_reset();
        pulse_start();
        prev_busy = lcd_busy;
        while (d_done !== 1'b1 && cyc < 4000) begin
            step();
            cyc++;
            if (d_valid === 1'b1) begin
                checks++;
                if (prev_busy !== 1'b0 || left != 0) begin
                    failures++;
                    $display("FAIL full_strobe_timing: strobe %0d prev_busy=%b bytes_left=%0d expected 0/0", n, prev_busy, left);
                end
                checks++;
                if (n >= 22) begin
                    failures++;
                    $display("FAIL full_extra_strobe: strobe %0d cmd=%0d expected none", n, d_cmd);
                end else if (d_cmd !== seq[n]) begin
                    failures++;
                    $display("FAIL full_cmd_order: strobe %0d cmd=%0d expected %0d", n, d_cmd, seq[n]);
                end
                if (d_cmd == CMD_LOAD) left = NB;
                n++;
            end else if (left > 0) begin
                checks++;
                if (d_datain !== 8'(NB - left)) begin
                    failures++;
                    $display("FAIL full_byte: byte %0d datain=%h expected %h", NB - left, d_datain, 8'(NB - left));
                end
                left--;
            end else begin
                checks++;
                if (d_datain !== 8'h00) begin
                    failures++;
                    $display("FAIL full_datain_idle: datain=%h expected 00", d_datain);
                end
            end
            prev_busy = lcd_busy;
        end
        checks++;
        if (cyc >= 4000 || n != 22 || left != 0 || d_count !== 5'd22 || d_done !== 1'b1) begin
            failures++;
            $display("FAIL full_end: cycles=%0d strobes=%0d left=%0d count=%0d done=%b expected <4000/22/0/22/1",
                     cyc, n, left, d_count, d_done);
        end
        model_en = 1'b0;
    endtask

    task automatic test_start_ignored();
        cmd_mem[0] = CMD_LOAD;
        do_reset();
        pulse_start();
        step();
        step();
        checks++;
        if (o1_valid !== 1'b1) begin
            failures++;
            $display("FAIL ign_first_strobe: valid=%b expected 1", o1_valid);
        end
        for (int k = 0; k < NB; k++) begin
            step();
            checks++;
            if ({o1_valid, o1_datain} !== {1'b0, 8'(k)}) begin
                failures++;
                $display("FAIL ign_byte: k=%0d valid=%b datain=%h expected 0/%h", k, o1_valid, o1_datain, 8'(k));
            end
            if (k == 40) start = 1'b1;
            if (k == 41) start = 1'b0;
        end
        step();
        step();
        checks++;
        if (o1_done !== 1'b1) begin
            failures++;
            $display("FAIL ign_done: done=%b expected 1", o1_done);
        end
        pulse_start();
        checks++;
        if (o1_done !== 1'b0 || o1_count !== 5'd0) begin
            failures++;
            $display("FAIL restart_clear: done=%b count=%0d expected 0/0", o1_done, o1_count);
        end
        step();
        step();
        checks++;
        if (o1_valid !== 1'b1 || o1_cmd !== 3'd0) begin
            failures++;
            $display("FAIL restart_strobe: valid=%b cmd=%0d expected 1/0", o1_valid, o1_cmd);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [29:0] v;
        cmd_mem[0] = CMD_LOAD;
        model_en = 1'b0;
        busy_manual = 1'b0;
        do_reset();
        pulse_start();
        step();
        step();
        for (int k = 0; k <= 50; k++) step();
        checks++;
        if (d_datain !== 8'd50) begin
            failures++;
            $display("FAIL mid_byte50: datain=%h expected 32", d_datain);
        end
        #2;
        reset = 1'b0;
        #1;
        v = {d_cmd_addr, d_img_addr, d_cmd, d_valid, d_datain, d_count, d_done};
        checks++;
        if (v !== 30'd0) begin
            failures++;
            $display("FAIL mid_async_reset: got %h expected 0", v);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({d_valid, d_datain, d_done} !== 10'd0) begin
                failures++;
                $display("FAIL mid_no_resume: cycle %0d valid=%b datain=%h done=%b expected 0", i, d_valid, d_datain, d_done);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        busy_manual = 1'b0;
        model_en = 1'b0;
        for (int i = 0; i < 32; i++) cmd_mem[i] = 3'd1;
        for (int i = 0; i < 128; i++) img_mem[i] = 8'(i);
        test_reset();
        test_single_load();
        test_busy_stall();
        test_full_run();
        test_start_ignored();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_cmd_feeder.md
Name: lcd_cmd_feeder

Overview:
Upstream driver for LCD_CTRL. It walks a command ROM and an image ROM and issues each command on lcd_cmd/lcd_cmd_valid only when LCD_CTRL is not busy. For every load command (code 0), it streams the image bytes on lcd_datain, one per cycle, starting the cycle after the command. It replaces bench-side stimulus sequencing with synthesizable RTL feeding LCD_CTRL at the top level.

Parameters:
IMG_BYTES, 108, bytes streamed per load command (12x9 image)
CMD_NUM, 22, commands executed per run
CMD_AW, 5, command ROM address width
IMG_AW, 7, image ROM address width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a run from command 0
cmd_rom_addr  output  CMD_AW  command ROM address
cmd_rom_data  input  3  command ROM data; synchronous ROM, valid 1 cycle after address
img_rom_addr  output  IMG_AW  image ROM address
img_rom_data  input  8  image ROM data; synchronous ROM, valid 1 cycle after address
lcd_busy  input  1  LCD_CTRL busy
lcd_cmd  output  3  command to LCD_CTRL
lcd_cmd_valid  output  1  command strobe, exactly 1 cycle per command
lcd_datain  output  8  image byte to LCD_CTRL
cmd_count  output  CMD_AW  number of commands issued this run
done  output  1  sticky run-complete flag

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; counters 0.
- States: IDLE, FETCH, WAIT_RDY, ISSUE, STREAM, GUARD, DONE.
- IDLE/DONE: start=1 -> FETCH, cmd_count=0, cmd_rom_addr=0, done cleared. start in any other state is ignored.
- FETCH: lasts 1 cycle (ROM latency). Latch cmd_rom_data into the command register on the cycle after. -> WAIT_RDY.
- WAIT_RDY: if lcd_busy=0 -> ISSUE; otherwise hold indefinitely.
- ISSUE (1 cycle):
  - lcd_cmd_valid=1; lcd_cmd=latched code; cmd_count increments on exit.
  - If code==0: img_rom_addr=0 and the byte counter is cleared -> STREAM.
  - Otherwise -> GUARD.
- STREAM (exactly IMG_BYTES cycles):
  - lcd_datain=img_rom_data, passed straight through from the registered ROM output, so byte k appears k+1 cycles after the ISSUE cycle.
  - img_rom_addr increments each cycle.
  - lcd_busy is ignored in this state.
  - After byte IMG_BYTES-1 -> GUARD.
- GUARD (1 cycle): ignores lcd_busy, covering the 1-cycle latency before LCD_CTRL raises busy. Then:
  - if cmd_count==CMD_NUM -> DONE, done=1;
  - else cmd_rom_addr=cmd_count -> FETCH.
- Output rules outside their active states:
  - lcd_cmd_valid=0 outside ISSUE.
  - lcd_cmd=0 outside ISSUE.
  - lcd_datain=0 outside STREAM; never high-Z.
- Command codes 1..7 are passed through unmodified; only code 0 triggers streaming.
- Minimum spacing between strobes: 3 cycles for non-load commands, IMG_BYTES+3 for loads, plus any busy time.
- Asynchronous reset mid-STREAM: outputs drop to 0 immediately; no resume; a new start is required after release.
- done stays high until the next start or reset.
- Counter widths: the byte counter is IMG_AW bits and never wraps (terminal count IMG_BYTES-1). cmd_count saturates at CMD_NUM.

Decomposition:
- Shared package lcd_pkg:
  - command code constants, with CMD_LOAD=3'd0;
  - state enum for this block;
  - IMG_BYTES/CMD_NUM defaults, reused by LCD_CTRL and the bench.
- Natural sub-module: lcd_img_streamer. It owns the byte counter, img_rom_addr and lcd_datain gating, and has a start/finish handshake with the main FSM.

Test Plan:
- Reset values: hold reset=0 for 2 cycles -> every output 0; state IDLE after release; start never pulsed -> lcd_cmd_valid stays 0 for 50 cycles.
- Single load: cmd ROM[0]=0, CMD_NUM=1, img ROM[k]=k, lcd_busy=0 -> one strobe with lcd_cmd=0; lcd_datain=0x00..0x6B on the 108 following cycles; done=1 two cycles after the last byte.
- Busy stall: command ROM=1,2 with lcd_busy forced high for 20 cycles after the first strobe -> second strobe appears no earlier than 1 cycle after busy falls; exactly 2 strobes; cmd_count=2.
- Full run: cmd1.dat contents with a behavioural LCD_CTRL busy model -> 22 strobes, codes in ROM order, each load followed by 108 contiguous bytes; done=1, cmd_count=22.
- Start ignored: pulse start during STREAM -> no restart; byte sequence uninterrupted; second start after done -> new run from command 0, done cleared.
- Reset mid-stream: assert reset at byte 50 -> lcd_datain=0 and lcd_cmd_valid=0 immediately (asynchronously); after release no activity until start.
